float_to_fixed_pipe: RTL and testbench

//  Pipelined IEEE-754 single-precision to signed fixed-point converter. It is the inverse of the
//  FP adder's normalise/combine path: it unpacks sign/exponent/mantissa and denormalises into Q-format.

---
 rtl/float_to_fixed_pipe_if.sv | 30 +++
 rtl/float_to_fixed_pipe.sv | 188 ++++++++++++++++++
 tb/tb_float_to_fixed_pipe.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/float_to_fixed_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : float_to_fixed_pipe_if
//  Function : Data-side bundle of the float-to-fixed converter: the float
//             input with its valid, and the fixed-point result with its flags.
//  Revision : 1.0 - initial release
// ============================================================================
interface float_to_fixed_pipe_if #(
    parameter int OUT_W = 24
);
    logic             in_valid;
    logic [31:0]      a;
    logic             out_valid;
    logic [OUT_W-1:0] q;
    logic             ovf;
    logic             nan;

    // Producer of floats / consumer of fixed-point results.
    modport master (
        output in_valid, a,
        input  out_valid, q, ovf, nan
    );

    // The converter itself.
    modport slave (
        input  in_valid, a,
        output out_valid, q, ovf, nan
    );
endinterface
`default_nettype wire

// File: rtl/float_to_fixed_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : float_to_fixed_pipe
//  Function : Four-stage IEEE-754 single to signed Q-format converter with a
//             global stall enable (unpack, shift, round/saturate, output).
//  Revision : 1.0 - initial release
// ============================================================================
module float_to_fixed_pipe #(
    parameter int OUT_W  = 24,
    parameter int FRAC_W = 12
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             en,
    float_to_fixed_pipe_if.slave  bus
);
    // Magnitude carries one bit above the sign position so that 2^(OUT_W-1)
    // (legal for negatives) and the first positive overflow stay distinct.
    localparam int MW = OUT_W + 1;
    localparam int LW = OUT_W + 24;
    localparam int SW = OUT_W + 2;

    localparam logic signed [9:0] c_sh_bias = 10'(FRAC_W - 150);
    localparam logic signed [9:0] c_sh_max  = 10'(OUT_W);
    localparam logic [OUT_W-1:0]  c_max_pos = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]  c_min_neg = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [SW-1:0]     c_max_pos_x = SW'(c_max_pos);
    localparam logic [SW-1:0]     c_min_mag_x = SW'(c_min_neg);

    // ---------------- S1: unpack and classify ----------------
    logic        r1_valid, r1_s, r1_zero, r1_inf, r1_nan;
    logic [7:0]  r1_e;
    logic [23:0] r1_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_s     <= 1'b0;
            r1_e     <= '0;
            r1_m     <= '0;
            r1_zero  <= 1'b0;
            r1_inf   <= 1'b0;
            r1_nan   <= 1'b0;
        end else if (en) begin
            r1_valid <= bus.in_valid;
            r1_s     <= bus.a[31];
            r1_e     <= bus.a[30:23];
            r1_m     <= {1'b1, bus.a[22:0]};
            r1_zero  <= (bus.a[30:23] == 8'h00);
            r1_inf   <= (bus.a[30:23] == 8'hFF) && (bus.a[22:0] == 23'd0);
            r1_nan   <= (bus.a[30:23] == 8'hFF) && (bus.a[22:0] != 23'd0);
        end
    end

    // ---------------- S2: denormalise into Q-format ----------------
    logic signed [9:0] w_sh;
    logic [9:0]        w_rsh;
    logic [24:0]       w_right;
    logic [LW-1:0]     w_wide;
    logic              w_over, w_round, w_big;
    logic [MW-1:0]     w_mag;

    assign w_sh = signed'({2'b00, r1_e}) + c_sh_bias;

    always_comb begin
        w_rsh   = '0;
        w_right = '0;
        w_wide  = '0;
        w_over  = 1'b0;
        w_round = 1'b0;
        if (!w_sh[9]) begin
            // Beyond OUT_W the leading one is far past the sign bit anyway.
            if (w_sh > c_sh_max) begin
                w_over = 1'b1;
            end else begin
                w_wide = {{OUT_W{1'b0}}, r1_m} << w_sh[5:0];
            end
        end else begin
            w_rsh = -w_sh;
            if (w_rsh <= 10'd24) begin
                w_right = {r1_m, 1'b0} >> w_rsh[4:0];
                w_round = w_right[0];
                w_wide  = LW'(w_right[24:1]);
            end
        end
        w_big = w_over | (|w_wide[LW-1:MW]);
        w_mag = w_wide[MW-1:0];
    end

    logic          r2_valid, r2_s, r2_zero, r2_inf, r2_nan, r2_round, r2_big;
    logic [MW-1:0] r2_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid <= 1'b0;
            r2_s     <= 1'b0;
            r2_zero  <= 1'b0;
            r2_inf   <= 1'b0;
            r2_nan   <= 1'b0;
            r2_round <= 1'b0;
            r2_big   <= 1'b0;
            r2_mag   <= '0;
        end else if (en) begin
            r2_valid <= r1_valid;
            r2_s     <= r1_s;
            r2_zero  <= r1_zero;
            r2_inf   <= r1_inf;
            r2_nan   <= r1_nan;
            r2_round <= w_round;
            r2_big   <= w_big;
            r2_mag   <= w_mag;
        end
    end

    // ---------------- S3: round half away from zero, saturate ----------------
    logic [SW-1:0]    w_sum;
    logic [OUT_W-1:0] w_q;
    logic             w_ovf;

    assign w_sum = {1'b0, r2_mag} + SW'(r2_round);

    always_comb begin
        w_q   = '0;
        w_ovf = 1'b0;
        if (r2_nan || r2_zero) begin
            w_q = '0;
        end else if (r2_inf) begin
            w_q   = r2_s ? c_min_neg : c_max_pos;
            w_ovf = 1'b1;
        end else if (!r2_s) begin
            if (r2_big || (w_sum > c_max_pos_x)) begin
                w_q   = c_max_pos;
                w_ovf = 1'b1;
            end else begin
                w_q = w_sum[OUT_W-1:0];
            end
        end else begin
            // Negating exactly 2^(OUT_W-1) wraps to the most negative code.
            if (r2_big || (w_sum > c_min_mag_x)) begin
                w_q   = c_min_neg;
                w_ovf = 1'b1;
            end else begin
                w_q = -w_sum[OUT_W-1:0];
            end
        end
    end

    logic             r3_valid, r3_ovf, r3_nan;
    logic [OUT_W-1:0] r3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_valid <= 1'b0;
            r3_ovf   <= 1'b0;
            r3_nan   <= 1'b0;
            r3_q     <= '0;
        end else if (en) begin
            r3_valid <= r2_valid;
            r3_ovf   <= w_ovf;
            r3_nan   <= r2_nan;
            r3_q     <= w_q;
        end
    end

    // ---------------- S4: output register ----------------
    logic             r_out_valid, r_ovf, r_nan;
    logic [OUT_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_nan       <= 1'b0;
            r_q         <= '0;
        end else if (en) begin
            r_out_valid <= r3_valid;
            r_ovf       <= r3_ovf;
            r_nan       <= r3_nan;
            r_q         <= r3_q;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.q         = r_q;
    assign bus.ovf       = r_ovf;
    assign bus.nan       = r_nan;
endmodule
`default_nettype wire

// File: tb/tb_float_to_fixed_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_float_to_fixed_pipe
//  Function : Directed self-checking bench for float_to_fixed_pipe
//             (OUT_W=24, FRAC_W=12) with hand-computed expected results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_float_to_fixed_pipe;
    logic clk;
    logic rst_n;
    logic en;
    int   n_checks;
    int   n_errors;

    float_to_fixed_pipe_if #(.OUT_W(24)) bus ();

    float_to_fixed_pipe #(
        .OUT_W  (24),
        .FRAC_W (12)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One isolated conversion: output must appear on exactly the fourth edge.
    task automatic run_one(input string tag, input logic [31:0] av,
                           input logic [23:0] eq, input logic eo, input logic enan);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = av;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_q"},     32'(bus.q),         32'(eq));
        check({tag, "_ovf"},   32'(bus.ovf),       32'(eo));
        check({tag, "_nan"},   32'(bus.nan),       32'(enan));
    endtask

    logic [31:0] s_in  [8];
    logic [23:0] s_exp [8];

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        en           = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = 32'h0;

        s_in[0] = 32'h3F800000; s_exp[0] = 24'h001000;   //  1.0
        s_in[1] = 32'h40000000; s_exp[1] = 24'h002000;   //  2.0
        s_in[2] = 32'h40400000; s_exp[2] = 24'h003000;   //  3.0
        s_in[3] = 32'h3F000000; s_exp[3] = 24'h000800;   //  0.5
        s_in[4] = 32'hBF800000; s_exp[4] = 24'hFFF000;   // -1.0
        s_in[5] = 32'h41200000; s_exp[5] = 24'h00A000;   //  10.0
        s_in[6] = 32'hBE800000; s_exp[6] = 24'hFFFC00;   // -0.25
        s_in[7] = 32'h42C80000; s_exp[7] = 24'h064000;   //  100.0

        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_q",     32'(bus.q),         32'd0);
        check("rst_ovf",   32'(bus.ovf),       32'd0);
        check("rst_nan",   32'(bus.nan),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_one("one",       32'h3F800000, 24'h001000, 1'b0, 1'b0);
        run_one("m2p5",      32'hC0200000, 24'hFFD800, 1'b0, 1'b0);
        run_one("half_lsb",  32'h39000000, 24'h000001, 1'b0, 1'b0);
        run_one("mhalf_lsb", 32'hB9000000, 24'hFFFFFF, 1'b0, 1'b0);
        run_one("qtr_lsb",   32'h38800000, 24'h000000, 1'b0, 1'b0);
        run_one("mqtr_lsb",  32'hB8800000, 24'h000000, 1'b0, 1'b0);
        run_one("p4096",     32'h45800000, 24'h7FFFFF, 1'b1, 1'b0);
        run_one("m2048",     32'hC5000000, 24'h800000, 1'b0, 1'b0);
        run_one("m2048p5",   32'hC5000800, 24'h800000, 1'b1, 1'b0);
        run_one("rnd_ovf_p", 32'h44FFFFFF, 24'h7FFFFF, 1'b1, 1'b0);
        run_one("rnd_min_n", 32'hC4FFFFFF, 24'h800000, 1'b0, 1'b0);
        run_one("pinf",      32'h7F800000, 24'h7FFFFF, 1'b1, 1'b0);
        run_one("minf",      32'hFF800000, 24'h800000, 1'b1, 1'b0);
        run_one("nan",       32'h7FC00000, 24'h000000, 1'b0, 1'b1);
        run_one("denorm",    32'h00000001, 24'h000000, 1'b0, 1'b0);
        run_one("mzero",     32'h80000000, 24'h000000, 1'b0, 1'b0);

        // Stalled stream: en pattern 1,0,0 repeating; NaN offered while stalled must be ignored.
        begin
            int   idx;
            int   got;
            logic en_last;
            idx     = 0;
            got     = 0;
            en_last = 1'b0;
            for (int cyc = 0; cyc < 60; cyc++) begin
                @(negedge clk);
                if (en_last && bus.out_valid) begin
                    if (got < 8) begin
                        check($sformatf("stream_q%0d", got), 32'(bus.q), 32'(s_exp[got]));
                        check($sformatf("stream_nan%0d", got), 32'(bus.nan), 32'd0);
                    end
                    got++;
                end
                en = (cyc % 3 == 0);
                if (en && idx < 8) begin
                    bus.in_valid = 1'b1;
                    bus.a        = s_in[idx];
                    idx++;
                end else if (en) begin
                    bus.in_valid = 1'b0;
                end else begin
                    bus.in_valid = 1'b1;
                    bus.a        = 32'h7FC00000;
                end
                en_last = en;
            end
            check("stream_count", 32'(got), 32'd8);
        end

        // Reset with three items in flight must discard them all.
        @(negedge clk);
        en           = 1'b1;
        bus.in_valid = 1'b1;
        bus.a        = 32'h3F800000;
        @(negedge clk);
        bus.a        = 32'h40000000;
        @(negedge clk);
        bus.a        = 32'h40400000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        rst_n        = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("flush_valid%0d", i), 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        run_one("post_rst", 32'h40000000, 24'h002000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
